// File: rtl/conv_pkg.sv
// Shared definitions for the convolutional encoder output path: block sizes,
// merge FSM states and the 3-stream bit interleave.
package conv_pkg;

  localparam int unsigned SMALL_BYTES    = 132;
  localparam int unsigned LARGE_BYTES    = 768;
  localparam int unsigned CNT_W          = 10;
  localparam int unsigned META_LARGE_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_META_RD,
    ST_META_LAT,
    ST_FETCH,
    ST_LATCH,
    ST_EMIT0,
    ST_EMIT1,
    ST_EMIT2
  } merge_state_t;

  // Restore codeword order: bit i of each stream lands at 3i, 3i+1, 3i+2.
  function automatic logic [23:0] interleave3(input logic [7:0] d0,
                                              input logic [7:0] d1,
                                              input logic [7:0] d2);
    logic [23:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      w[3*i]   = d0[i];
      w[3*i+1] = d1[i];
      w[3*i+2] = d2[i];
    end
    return w;
  endfunction

endpackage

// File: rtl/conv_stream_merge.sv
// Pops one byte from each of the three encoder stream FIFOs per group and emits
// them as three bit-interleaved bytes on a framed valid/ready stream.
module conv_stream_merge
  import conv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] meta_data,
  input  logic       meta_empty,
  output logic       meta_rdreq,
  input  logic [7:0] fifo0_data,
  input  logic [7:0] fifo1_data,
  input  logic [7:0] fifo2_data,
  input  logic       fifo0_empty,
  input  logic       fifo1_empty,
  input  logic       fifo2_empty,
  output logic       fifo_rdreq,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sop,
  output logic       out_eop,
  output logic       busy,
  output logic       blk_done
);

  merge_state_t     r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_large;
  logic [15:0]      r_word_hi;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_sop;
  logic             r_eop;
  logic             r_meta_rdreq;
  logic             r_busy;
  logic             r_blk_done;

  logic             w_fetch;
  logic             w_accept;
  logic             w_last;
  logic [23:0]      w_word;
  logic             w_unused_meta;

  // Pop only in the same cycle that all three streams show data.
  assign w_fetch  = (r_state == ST_FETCH) && !fifo0_empty && !fifo1_empty && !fifo2_empty;
  assign w_accept = r_valid && out_ready;
  assign w_last   = r_large ? (r_cnt == CNT_W'(LARGE_BYTES - 1))
                            : (r_cnt == CNT_W'(SMALL_BYTES - 1));
  assign w_word   = interleave3(fifo0_data, fifo1_data, fifo2_data);
  assign w_unused_meta = ^meta_data[7:1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_large      <= 1'b0;
      r_word_hi    <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_sop        <= 1'b0;
      r_eop        <= 1'b0;
      r_meta_rdreq <= 1'b0;
      r_busy       <= 1'b0;
      r_blk_done   <= 1'b0;
    end else begin
      r_meta_rdreq <= 1'b0;
      r_blk_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!meta_empty) begin
            r_state      <= ST_META_RD;
            r_meta_rdreq <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        ST_META_RD: r_state <= ST_META_LAT;
        ST_META_LAT: begin
          r_large <= meta_data[META_LARGE_BIT];
          r_cnt   <= '0;
          r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (w_fetch) r_state <= ST_LATCH;
        end
        // Stream bytes are valid this cycle; first output byte goes straight out.
        ST_LATCH: begin
          r_word_hi <= w_word[23:8];
          r_data    <= w_word[7:0];
          r_valid   <= 1'b1;
          r_sop     <= (r_cnt == '0);
          r_state   <= ST_EMIT0;
        end
        ST_EMIT0: begin
          if (w_accept) begin
            r_data  <= r_word_hi[7:0];
            r_sop   <= 1'b0;
            r_state <= ST_EMIT1;
          end
        end
        ST_EMIT1: begin
          if (w_accept) begin
            r_data  <= r_word_hi[15:8];
            r_eop   <= w_last;
            r_state <= ST_EMIT2;
          end
        end
        ST_EMIT2: begin
          if (w_accept) begin
            r_valid <= 1'b0;
            r_eop   <= 1'b0;
            if (w_last) begin
              r_state    <= ST_IDLE;
              r_busy     <= 1'b0;
              r_blk_done <= 1'b1;
            end else begin
              r_cnt   <= r_cnt + CNT_W'(1);
              r_state <= ST_FETCH;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign meta_rdreq = r_meta_rdreq;
  assign fifo_rdreq = w_fetch;
  assign out_data   = r_data;
  assign out_valid  = r_valid;
  assign out_sop    = r_sop;
  assign out_eop    = r_eop;
  assign busy       = r_busy;
  assign blk_done   = r_blk_done;

endmodule

// File: tb/tb_conv_stream_merge.sv
// Bench for conv_stream_merge: models the stream/meta FIFOs and checks every
// accepted byte against a codeword-order reference built from the pushed data.
module tb_conv_stream_merge;

  logic       clk;
  logic       reset;
  logic [7:0] meta_data;
  logic       meta_empty;
  logic       meta_rdreq;
  logic [7:0] fifo0_data, fifo1_data, fifo2_data;
  logic       fifo0_empty, fifo1_empty, fifo2_empty;
  logic       fifo_rdreq;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sop;
  logic       out_eop;
  logic       busy;
  logic       blk_done;

  conv_stream_merge dut (
    .clk(clk), .reset(reset),
    .meta_data(meta_data), .meta_empty(meta_empty), .meta_rdreq(meta_rdreq),
    .fifo0_data(fifo0_data), .fifo1_data(fifo1_data), .fifo2_data(fifo2_data),
    .fifo0_empty(fifo0_empty), .fifo1_empty(fifo1_empty), .fifo2_empty(fifo2_empty),
    .fifo_rdreq(fifo_rdreq),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .busy(busy), .blk_done(blk_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } exp_t;

  logic [7:0] q0[$], q1[$], q2[$], mq[$];
  exp_t       exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int duty    = 100;
  logic starve2 = 1'b0;

  int cyc = 0, n_acc = 0, n_pop = 0, n_meta = 0, n_eop = 0, n_done = 0;
  int blk_bytes = 0, meta_cyc = 0, sop_cyc = 0, done_cyc = 0;
  logic [7:0] first3 [3];
  logic       prev_stall = 1'b0, prev_eop_acc = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_sop = 1'b0, prev_eop = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic update_flags();
    fifo0_empty = (q0.size() == 0);
    fifo1_empty = (q1.size() == 0);
    fifo2_empty = (q2.size() == 0) || starve2;
    meta_empty  = (mq.size() == 0);
  endtask

  // Reference: lay the coded bits out in natural order d0_k,d1_k,d2_k and cut bytes LSB-first.
  task automatic push_block(input logic [7:0] meta, input bit pattern);
    int   n;
    logic [7:0] d0, d1, d2;
    logic bits[$];
    logic [7:0] b;
    n = meta[0] ? 768 : 132;
    mq.push_back(meta);
    for (int g = 0; g < n; g++) begin
      d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
      if (pattern && g == 0) begin d0 = 8'hFF; d1 = 8'h00; d2 = 8'h00; end
      q0.push_back(d0); q1.push_back(d1); q2.push_back(d2);
      bits.delete();
      for (int k = 0; k < 8; k++) begin
        bits.push_back(d0[k]); bits.push_back(d1[k]); bits.push_back(d2[k]);
      end
      for (int j = 0; j < 3; j++) begin
        for (int k = 0; k < 8; k++) b[k] = bits[8*j + k];
        exp_q.push_back('{d: b, sop: (g == 0 && j == 0), eop: (g == n - 1 && j == 2)});
      end
    end
    update_flags();
  endtask

  task automatic tick();
    logic fr, mr, acc;
    exp_t e;
    @(negedge clk);
    out_ready = ($urandom_range(0, 99) < 32'(duty));
    cyc++;
    fr = fifo_rdreq;
    mr = meta_rdreq;
    chk("blk_done", 32'(blk_done), 32'(prev_eop_acc));
    if (blk_done) begin
      n_done++;
      done_cyc = cyc;
      chk("busy_at_done", 32'(busy), 0);
    end
    if (fr) chk("pop_while_empty", {29'd0, fifo0_empty, fifo1_empty, fifo2_empty}, 0);
    if (prev_stall) begin
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_data", 32'(out_data), 32'(prev_data));
      chk("hold_flags", {30'd0, out_sop, out_eop}, {30'd0, prev_sop, prev_eop});
    end
    if (out_valid && out_sop && !prev_stall) sop_cyc = cyc;
    acc = out_valid && out_ready;
    if (acc) begin
      if (exp_q.size() == 0) chk("extra_byte", 32'(exp_q.size()), 1);
      else begin
        e = exp_q.pop_front();
        chk("data", 32'(out_data), 32'(e.d));
        chk("sop", 32'(out_sop), 32'(e.sop));
        chk("eop", 32'(out_eop), 32'(e.eop));
      end
      if (out_sop) blk_bytes = 0;
      if (blk_bytes < 3) first3[blk_bytes] = out_data;
      blk_bytes++;
      n_acc++;
      if (out_eop) n_eop++;
    end
    if (mr) meta_cyc = cyc;
    prev_stall   = out_valid && !out_ready;
    prev_data    = out_data;
    prev_sop     = out_sop;
    prev_eop     = out_eop;
    prev_eop_acc = acc && out_eop;
    if (fr) n_pop++;
    @(posedge clk);
    #1;
    if (fr && q0.size() > 0 && q1.size() > 0 && q2.size() > 0) begin
      fifo0_data = q0.pop_front();
      fifo1_data = q1.pop_front();
      fifo2_data = q2.pop_front();
    end
    if (mr) begin
      n_meta++;
      if (mq.size() > 0) meta_data = mq.pop_front();
    end
    update_flags();
  endtask

  task automatic run_blocks(input int target, input int budget);
    int start;
    start = n_done;
    for (int i = 0; i < budget && n_done < start + target; i++) tick();
    chk("blocks_done_in_budget", 32'(n_done - start), 32'(target));
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_outs"}, {24'd0, meta_rdreq, fifo_rdreq, out_valid, out_sop, out_eop, busy, blk_done, 1'b0},
        32'd0);
    chk({tag, "_data"}, 32'(out_data), 0);
  endtask

  int a0, p0, m0, e0, d0c;

  initial begin
    reset = 1'b1; out_ready = 1'b0; meta_data = '0;
    fifo0_data = '0; fifo1_data = '0; fifo2_data = '0;
    update_flags();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    // Interleave pattern + small block, full throughput, latency.
    a0 = n_acc; p0 = n_pop; m0 = n_meta; e0 = n_eop;
    push_block(8'h00, 1'b1);
    duty = 100;
    run_blocks(1, 3000);
    chk("pattern_b0", 32'(first3[0]), 32'h49);
    chk("pattern_b1", 32'(first3[1]), 32'h92);
    chk("pattern_b2", 32'(first3[2]), 32'h24);
    chk("latency", 32'(sop_cyc - meta_cyc), 4);
    chk("small_bytes", 32'(n_acc - a0), 396);
    chk("small_pops", 32'(n_pop - p0), 132);
    chk("small_meta_pops", 32'(n_meta - m0), 1);
    chk("small_eops", 32'(n_eop - e0), 1);

    // Large block with random upper meta bits.
    a0 = n_acc; p0 = n_pop;
    push_block({7'($urandom), 1'b1}, 1'b0);
    run_blocks(1, 6000);
    chk("large_bytes", 32'(n_acc - a0), 2304);
    chk("large_pops", 32'(n_pop - p0), 768);
    chk("large_busy_idle", 32'(busy), 0);

    // Backpressure at 30% and a 20-cycle starve on stream 2.
    a0 = n_acc;
    duty = 30;
    push_block(8'h00, 1'b0);
    for (int i = 0; i < 2000 && n_acc - a0 < 60; i++) tick();
    starve2 = 1'b1;
    update_flags();
    p0 = n_pop;
    repeat (20) tick();
    chk("starve_no_pop", 32'(n_pop - p0), 0);
    starve2 = 1'b0;
    update_flags();
    run_blocks(1, 5000);
    chk("bp_bytes", 32'(n_acc - a0), 396);

    // Back-to-back blocks queued together.
    duty = 100;
    m0 = n_meta; a0 = n_acc;
    push_block(8'h01, 1'b0);
    push_block(8'h00, 1'b0);
    run_blocks(1, 6000);
    d0c = done_cyc;
    run_blocks(1, 3000);
    chk("b2b_meta_pops", 32'(n_meta - m0), 2);
    chk("b2b_bytes", 32'(n_acc - a0), 2700);
    chk("b2b_gap_ok", 32'((sop_cyc - d0c) >= 3), 1);

    // Reset during EMIT1 of group 50.
    push_block(8'h00, 1'b0);
    a0 = n_acc;
    for (int i = 0; i < 2000 && n_acc - a0 < 151; i++) tick();
    @(negedge clk);
    chk("pre_reset_valid", 32'(out_valid), 1);
    chk("pre_reset_data", 32'(out_data), 32'(exp_q[0].d));
    reset = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    reset = 1'b0;
    q0.delete(); q1.delete(); q2.delete(); mq.delete(); exp_q.delete();
    prev_stall = 1'b0; prev_eop_acc = 1'b0;
    update_flags();
    a0 = n_acc; p0 = n_pop;
    push_block({7'($urandom), 1'b0}, 1'b1);
    run_blocks(1, 3000);
    chk("post_reset_bytes", 32'(n_acc - a0), 396);
    chk("post_reset_pops", 32'(n_pop - p0), 132);
    chk("post_reset_pattern", 32'(first3[0]), 32'h49);
    chk("leftover_expected", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_stream_merge.md
Name: conv_stream_merge

Overview:
- Reader on the far side of the convolutional encoder's three output byte FIFOs (streams d0, d1, d2) and its per-block meta FIFO.
- Pops one byte from each stream FIFO per group and bit-interleaves them back into natural rate-1/3 codeword order (d0_k, d1_k, d2_k, ...).
- Emits the result as a framed byte stream under a valid/ready handshake toward the downstream rate-matching / transmit stage.

Parameters:
- SMALL_BYTES, 132, bytes per stream for a small block (meta bit 0 = 0; 1056 coded bits per stream).
- LARGE_BYTES, 768, bytes per stream for a large block (meta bit 0 = 1; 6144 coded bits per stream).
- CNT_W, 10, group counter width; must hold LARGE_BYTES-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- meta_data  in  8  block meta word; bit 0 = large-block flag, other bits ignored.
- meta_empty  in  1  meta FIFO empty.
- meta_rdreq  out  1  meta FIFO pop; data valid the cycle after.
- fifo0_data / fifo1_data / fifo2_data  in  8 each  stream d0/d1/d2 bytes; bit 0 = earliest coded bit.
- fifo0_empty / fifo1_empty / fifo2_empty  in  1 each  stream FIFO empty flags.
- fifo_rdreq  out  1  common pop to all three stream FIFOs; data valid the cycle after.
- out_data  out  8  merged output byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accept.
- out_sop  out  1  first byte of block, qualified by out_valid.
- out_eop  out  1  last byte of block, qualified by out_valid.
- busy  out  1  high from leaving IDLE until returning to IDLE.
- blk_done  out  1  one-cycle pulse on the cycle after the eop byte is accepted.

Behaviour:
- Reset (synchronous, active-high): state IDLE; group counter 0; large flag 0; all outputs 0 (meta_rdreq, fifo_rdreq, out_valid, out_sop, out_eop, busy, blk_done, out_data = 0x00).
- States: IDLE, META_RD, META_LAT, FETCH, LATCH, EMIT0, EMIT1, EMIT2.
- IDLE: if !meta_empty, go to META_RD.
- META_RD: meta_rdreq = 1 for exactly one cycle; go to META_LAT.
- META_LAT: latch meta_data[0] into the large flag; clear the group counter; go to FETCH.
- FETCH:
  - Wait until all three of fifo0_empty, fifo1_empty and fifo2_empty are 0.
  - In that cycle assert fifo_rdreq for one cycle and go to LATCH.
  - Never pop while any stream FIFO is empty. Partial availability stalls with no pop.
- LATCH: capture the three bytes into a 24-bit word W, where W[3i] = d0[i], W[3i+1] = d1[i], W[3i+2] = d2[i] for i = 0..7; go to EMIT0.
- EMITj (j = 0, 1, 2):
  - out_data = W[8j+7:8j], out_valid = 1.
  - Advance only on out_valid && out_ready.
  - out_data must remain stable while out_valid && !out_ready.
- out_sop: 1 in EMIT0 when the group counter = 0.
- out_eop: 1 in EMIT2 when the group counter = N-1, where N = LARGE_BYTES if the large flag is set, else SMALL_BYTES.
- Leaving EMIT2 on accept:
  - If counter = N-1: go to IDLE and pulse blk_done on the next cycle.
  - Else: increment the counter and go to FETCH.
- Block totals: 3N output bytes per block (396 small, 2304 large); exactly N stream pops and 1 meta pop.
- Throughput: no overlap between fetch and emit. With out_ready held high, each group takes 5 cycles (FETCH, LATCH, EMIT0..2).
- Latency: the first out_valid appears 4 cycles after meta_rdreq (META_LAT, FETCH, LATCH, EMIT0), provided the stream FIFOs are already non-empty.
- Meta present while busy: ignored until the return to IDLE. Back-to-back blocks add 3 cycles of gap (IDLE, META_RD, META_LAT).
- Reset mid-block: abandons the block immediately with no further pops. Stream FIFO residue is not flushed; upstream reset is responsible for that.
- out_ready high outside EMIT states: no effect.
- Counter never wraps: N-1 is at most 767, which fits in CNT_W.

Decomposition:
- Shared package conv_pkg holds:
  - state enum;
  - SMALL_BYTES and LARGE_BYTES constants, so encoder and merge use one definition;
  - META_LARGE_BIT = 0;
  - interleave3 function (3×8 → 24 bits).
- One natural sub-module: bit_interleave3, pure combinational. Keep it only if the flow forbids functions; otherwise use the package function.

Test Plan:
- Interleave pattern: meta = 0x00, first group d0 = 0xFF, d1 = 0x00, d2 = 0x00, out_ready = 1 → first three bytes are 0x49, 0x92, 0x24; out_sop on 0x49.
- Small block: meta = 0x00, 132 groups of random bytes → 396 bytes, each matching the golden interleave; exactly 132 fifo_rdreq pulses; out_eop on byte 396 only; blk_done one cycle later.
- Large block: meta = 0x01, 768 groups → 2304 bytes; eop on byte 2304; the cycle after the eop accept returns to IDLE with busy = 0.
- Starvation and backpressure: fifo2_empty held 1 for 20 cycles mid-block → fifo_rdreq stays 0. Random out_ready at 30% duty → out_data stable while stalled, no byte lost or duplicated.
- Back-to-back blocks: two meta words queued (0x01 then 0x00) → one meta pop per block; second sop 3 cycles after first blk_done at the earliest.
- Reset mid-block: reset during EMIT1 of group 50 → next cycle all outputs 0 and state IDLE; a new meta block afterwards starts with sop and counter 0.
